// File: rtl/watch_pkg.sv
// Shared definitions for the digital-watch controller: display mode codes,
// BCD time records, edit-cursor positions and the 7-segment code table.
package watch_pkg;

  localparam logic [2:0] MODE_WATCH     = 3'b000;
  localparam logic [2:0] MODE_STOPWATCH = 3'b001;
  localparam logic [2:0] MODE_ALARM     = 3'b010;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Edit cursor positions, least significant digit first.
  localparam logic [1:0] CUR_MIN_O = 2'd0;
  localparam logic [1:0] CUR_MIN_T = 2'd1;
  localparam logic [1:0] CUR_HR_O  = 2'd2;
  localparam logic [1:0] CUR_HR_T  = 2'd3;

  typedef struct packed {
    logic [3:0] hr_t;
    logic [3:0] hr_o;
    logic [3:0] min_t;
    logic [3:0] min_o;
  } hhmm_t;

  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
  } mmss_t;

  typedef enum logic {
    SW_STOPPED = 1'b0,
    SW_RUNNING = 1'b1
  } sw_state_e;

  // Segment patterns {g,f,e,d,c,b,a}; non-decimal codes stay dark.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return SEG_BLANK;
    endcase
  endfunction

  // One BCD digit step that wraps to 0 after reaching max.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d, input logic [3:0] max);
    return (d >= max) ? 4'd0 : d + 4'd1;
  endfunction

  // Manual edit step on the digit under the cursor. Hour ones is limited to
  // 0-3 in the twenties, and moving hour tens to 2 pulls an oversized hour
  // ones back to 3 so the time never reads past 23.
  function automatic hhmm_t inc_digit(input hhmm_t t, input logic [1:0] cur);
    hhmm_t r;
    r = t;
    case (cur)
      CUR_MIN_O: r.min_o = bcd_inc(t.min_o, 4'd9);
      CUR_MIN_T: r.min_t = bcd_inc(t.min_t, 4'd5);
      CUR_HR_O:  r.hr_o  = bcd_inc(t.hr_o, (t.hr_t == 4'd2) ? 4'd3 : 4'd9);
      default: begin
        r.hr_t = bcd_inc(t.hr_t, 4'd2);
        if (r.hr_t == 4'd2 && t.hr_o > 4'd3) r.hr_o = 4'd3;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// BCD to 7-segment decoder (active-high segments {g,f,e,d,c,b,a}).
// Ports: bcd (4-bit digit in), seg (7-bit pattern out, dark for 10-15).
module seven_seg_decoder
  import watch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  assign seg = seg_code(bcd);

endmodule

// File: rtl/watch_ctrl.sv
// Digital-watch controller: time of day, stopwatch and alarm on four 7-seg
// digits. Buttons are edge-detected against their previous-cycle level.
// Ports:
//   clk, resetTime (sync, active-high)
//   mode[2:0]    : 000 watch HH:MM, 001 stopwatch MM:SS, 010 alarm HH:MM, else blank
//   setValue     : level, edit watch or alarm in modes 000/010
//   upTime, nextDigit : edit increment / cursor advance (rising edge)
//   start_resume, stop : stopwatch control (rising edge); stop also silences alarm
//   digit3..digit0 : segment patterns, digit3 leftmost
//   alarmBeep    : high while the alarm sounds
module watch_ctrl
  import watch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic       clk,
  input  logic       resetTime,
  input  logic [2:0] mode,
  input  logic       setValue,
  input  logic       upTime,
  input  logic       nextDigit,
  input  logic       start_resume,
  input  logic       stop,
  output logic [6:0] digit3,
  output logic [6:0] digit2,
  output logic [6:0] digit1,
  output logic [6:0] digit0,
  output logic       alarmBeep
);

  localparam int CW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  logic [CW-1:0] tick_cnt;
  logic          tick;

  logic sv_q, up_q, nd_q, sr_q, st_q;
  logic sv_rise, sv_fall, up_rise, nd_rise, sr_rise, st_rise;

  logic edit_watch, edit_alarm, editing;
  logic [1:0] cursor, cursor_nx, cur_eff;

  hhmm_t      watch_hm, watch_hm_nx;
  logic [3:0] sec_t, sec_o, sec_t_nx, sec_o_nx;
  logic       c_so, c_st, c_mo, c_mt;

  hhmm_t alarm_hm, alarm_hm_nx;
  logic  armed, armed_nx, beep_nx;

  mmss_t     sw, sw_nx;
  sw_state_e sw_state, sw_state_nx;
  logic      sw_count, sw_clear;
  logic      w_so, w_st, w_mo;

  logic [3:0] bcd3, bcd2, bcd1, bcd0;
  logic [6:0] seg3, seg2, seg1, seg0;
  logic       blank;

  // Input edge detection; history is cleared in reset so a level held
  // through reset release is seen as a fresh press.
  assign sv_rise = setValue & ~sv_q;
  assign sv_fall = ~setValue & sv_q;
  assign up_rise = upTime & ~up_q;
  assign nd_rise = nextDigit & ~nd_q;
  assign sr_rise = start_resume & ~sr_q;
  assign st_rise = stop & ~st_q;

  assign tick = (tick_cnt == CW'(TICKS_PER_SEC - 1));

  assign edit_watch = setValue && (mode == MODE_WATCH);
  assign edit_alarm = setValue && (mode == MODE_ALARM);
  assign editing    = edit_watch || edit_alarm;

  // Entering edit restarts the cursor in the same cycle, so an upTime edge
  // arriving together with the setValue rise already lands on minute ones.
  assign cur_eff   = sv_rise ? CUR_MIN_O : cursor;
  assign cursor_nx = !editing ? cursor : (nd_rise ? cur_eff + 2'd1 : cur_eff);

  always_comb begin
    watch_hm_nx = watch_hm;
    sec_t_nx    = sec_t;
    sec_o_nx    = sec_o;
    c_so = (sec_o == 4'd9);
    c_st = c_so && (sec_t == 4'd5);
    c_mo = c_st && (watch_hm.min_o == 4'd9);
    c_mt = c_mo && (watch_hm.min_t == 4'd5);
    if (edit_watch) begin
      sec_t_nx = 4'd0;
      sec_o_nx = 4'd0;
      if (up_rise) watch_hm_nx = inc_digit(watch_hm, cur_eff);
    end else if (tick) begin
      sec_o_nx = bcd_inc(sec_o, 4'd9);
      if (c_so) sec_t_nx = bcd_inc(sec_t, 4'd5);
      if (c_st) watch_hm_nx.min_o = bcd_inc(watch_hm.min_o, 4'd9);
      if (c_mo) watch_hm_nx.min_t = bcd_inc(watch_hm.min_t, 4'd5);
      if (c_mt) begin
        if (watch_hm.hr_t == 4'd2 && watch_hm.hr_o == 4'd3) begin
          watch_hm_nx.hr_t = 4'd0;
          watch_hm_nx.hr_o = 4'd0;
        end else if (watch_hm.hr_o == 4'd9) begin
          watch_hm_nx.hr_o = 4'd0;
          watch_hm_nx.hr_t = watch_hm.hr_t + 4'd1;
        end else begin
          watch_hm_nx.hr_o = watch_hm.hr_o + 4'd1;
        end
      end
    end
  end

  assign alarm_hm_nx = (edit_alarm && up_rise) ? inc_digit(alarm_hm, cur_eff) : alarm_hm;

  // A stop press while sounding disarms and drops the beep immediately
  // rather than letting the still-armed compare hold it for one more cycle.
  always_comb begin
    armed_nx = armed;
    if (st_rise && alarmBeep) armed_nx = 1'b0;
    if (sv_fall && (mode == MODE_ALARM)) armed_nx = 1'b1;
  end

  assign beep_nx = armed && (watch_hm == alarm_hm) && !(st_rise && alarmBeep);

  // Stopwatch run/stop control: state register
  always_ff @(posedge clk) begin
    if (resetTime) sw_state <= SW_STOPPED;
    else           sw_state <= sw_state_nx;
  end

  // Stopwatch next state
  always_comb begin
    sw_state_nx = sw_state;
    case (sw_state)
      SW_STOPPED: if (sr_rise) sw_state_nx = SW_RUNNING;
      SW_RUNNING: if (st_rise) sw_state_nx = SW_STOPPED;
      default:    sw_state_nx = SW_STOPPED;
    endcase
  end

  // Stopwatch outputs: the pausing cycle does not count
  always_comb begin
    sw_count = 1'b0;
    sw_clear = 1'b0;
    case (sw_state)
      SW_RUNNING: sw_count = tick && !st_rise;
      default:    sw_clear = st_rise && !sr_rise;
    endcase
  end

  always_comb begin
    sw_nx = sw;
    w_so  = (sw.sec_o == 4'd9);
    w_st  = w_so && (sw.sec_t == 4'd5);
    w_mo  = w_st && (sw.min_o == 4'd9);
    if (sw_clear) begin
      sw_nx = '0;
    end else if (sw_count) begin
      sw_nx.sec_o = bcd_inc(sw.sec_o, 4'd9);
      if (w_so) sw_nx.sec_t = bcd_inc(sw.sec_t, 4'd5);
      if (w_st) sw_nx.min_o = bcd_inc(sw.min_o, 4'd9);
      if (w_mo) sw_nx.min_t = bcd_inc(sw.min_t, 4'd5);
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (resetTime) begin
      tick_cnt  <= '0;
      sv_q      <= 1'b0;
      up_q      <= 1'b0;
      nd_q      <= 1'b0;
      sr_q      <= 1'b0;
      st_q      <= 1'b0;
      cursor    <= CUR_MIN_O;
      watch_hm  <= '0;
      sec_t     <= 4'd0;
      sec_o     <= 4'd0;
      alarm_hm  <= '0;
      armed     <= 1'b0;
      alarmBeep <= 1'b0;
      sw        <= '0;
    end else begin
      tick_cnt  <= tick ? '0 : tick_cnt + CW'(1);
      sv_q      <= setValue;
      up_q      <= upTime;
      nd_q      <= nextDigit;
      sr_q      <= start_resume;
      st_q      <= stop;
      cursor    <= cursor_nx;
      watch_hm  <= watch_hm_nx;
      sec_t     <= sec_t_nx;
      sec_o     <= sec_o_nx;
      alarm_hm  <= alarm_hm_nx;
      armed     <= armed_nx;
      alarmBeep <= beep_nx;
      sw        <= sw_nx;
    end
  end

  // Display source select
  always_comb begin
    blank = 1'b0;
    bcd3  = 4'd0;
    bcd2  = 4'd0;
    bcd1  = 4'd0;
    bcd0  = 4'd0;
    case (mode)
      MODE_WATCH: begin
        bcd3 = watch_hm.hr_t;  bcd2 = watch_hm.hr_o;
        bcd1 = watch_hm.min_t; bcd0 = watch_hm.min_o;
      end
      MODE_STOPWATCH: begin
        bcd3 = sw.min_t; bcd2 = sw.min_o;
        bcd1 = sw.sec_t; bcd0 = sw.sec_o;
      end
      MODE_ALARM: begin
        bcd3 = alarm_hm.hr_t;  bcd2 = alarm_hm.hr_o;
        bcd1 = alarm_hm.min_t; bcd0 = alarm_hm.min_o;
      end
      default: blank = 1'b1;
    endcase
  end

  seven_seg_decoder u_dec3 (.bcd(bcd3), .seg(seg3));
  seven_seg_decoder u_dec2 (.bcd(bcd2), .seg(seg2));
  seven_seg_decoder u_dec1 (.bcd(bcd1), .seg(seg1));
  seven_seg_decoder u_dec0 (.bcd(bcd0), .seg(seg0));

  assign digit3 = blank ? SEG_BLANK : seg3;
  assign digit2 = blank ? SEG_BLANK : seg2;
  assign digit1 = blank ? SEG_BLANK : seg1;
  assign digit0 = blank ? SEG_BLANK : seg0;

endmodule

// File: tb/tb_watch_ctrl.sv
// Directed bench for watch_ctrl with one tick per clock cycle.
module tb_watch_ctrl;

  logic       clk = 1'b0;
  logic       resetTime = 1'b1;
  logic [2:0] mode = 3'b000;
  logic       setValue = 1'b0;
  logic       upTime = 1'b0;
  logic       nextDigit = 1'b0;
  logic       start_resume = 1'b0;
  logic       stop = 1'b0;
  logic [6:0] digit3, digit2, digit1, digit0;
  logic       alarmBeep;

  int checks = 0;
  int errors = 0;

  localparam int K_UP = 0, K_ND = 1, K_SR = 2, K_ST = 3;

  watch_ctrl #(.TICKS_PER_SEC(1)) dut (
    .clk(clk), .resetTime(resetTime), .mode(mode), .setValue(setValue),
    .upTime(upTime), .nextDigit(nextDigit), .start_resume(start_resume),
    .stop(stop), .digit3(digit3), .digit2(digit2), .digit1(digit1),
    .digit0(digit0), .alarmBeep(alarmBeep)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  mode;
    logic        sv;
    logic        up;
    logic        nd;
    logic [27:0] exp_digits;
    logic        exp_beep;
  } vec_t;

  vec_t vt [18];

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
      8: return 7'h7F; 9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [27:0] show(input int a, input int b);
    return {seg(a / 10), seg(a % 10), seg(b / 10), seg(b % 10)};
  endfunction

  function automatic vec_t arow(input logic sv, input logic up, input logic nd,
                                input int h, input int m);
    vec_t r;
    r.mode = 3'b010; r.sv = sv; r.up = up; r.nd = nd;
    r.exp_digits = show(h, m); r.exp_beep = 1'b0;
    return r;
  endfunction

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int k);
    case (k)
      K_UP: upTime = 1'b1;
      K_ND: nextDigit = 1'b1;
      K_SR: start_resume = 1'b1;
      default: stop = 1'b1;
    endcase
    tick1();
    upTime = 1'b0; nextDigit = 1'b0; start_resume = 1'b0; stop = 1'b0;
    tick1();
  endtask

  task automatic press_n(input int k, input int n);
    for (int i = 0; i < n; i++) press(k);
  endtask

  task automatic chk_d(input string name, input logic [27:0] exp);
    logic [27:0] act;
    act = {digit3, digit2, digit1, digit0};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: digits got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic exp);
    checks++;
    if (alarmBeep !== exp) begin
      errors++;
      $display("FAIL %s: alarmBeep got %b want %b", name, alarmBeep, exp);
    end
  endtask

  initial begin
    // Alarm programming: 4 ups on min ones, cursor, 2 ups on min tens with
    // a combined up+next on the last, then 1 up on hour ones -> 01:24.
    vt[0]  = arow(1, 0, 0, 0, 0);
    vt[1]  = arow(1, 1, 0, 0, 1);
    vt[2]  = arow(1, 0, 0, 0, 1);
    vt[3]  = arow(1, 1, 0, 0, 2);
    vt[4]  = arow(1, 0, 0, 0, 2);
    vt[5]  = arow(1, 1, 0, 0, 3);
    vt[6]  = arow(1, 0, 0, 0, 3);
    vt[7]  = arow(1, 1, 0, 0, 4);
    vt[8]  = arow(1, 0, 0, 0, 4);
    vt[9]  = arow(1, 0, 1, 0, 4);
    vt[10] = arow(1, 0, 0, 0, 4);
    vt[11] = arow(1, 1, 0, 0, 14);
    vt[12] = arow(1, 0, 0, 0, 14);
    vt[13] = arow(1, 1, 1, 0, 24);
    vt[14] = arow(1, 0, 0, 0, 24);
    vt[15] = arow(1, 1, 0, 1, 24);
    vt[16] = arow(1, 0, 0, 1, 24);
    vt[17] = arow(0, 0, 0, 1, 24);

    // Reset state
    repeat (50) tick1();
    mode = 3'b000; #1 chk_d("rst_watch", show(0, 0));
    mode = 3'b001; #1 chk_d("rst_stopwatch", show(0, 0));
    mode = 3'b010; #1 chk_d("rst_alarm", show(0, 0));
    chk_b("rst_beep", 1'b0);
    mode = 3'b000;
    resetTime = 1'b0;

    // Free-running watch
    repeat (59) tick1();
    chk_d("watch_59s", show(0, 0));
    tick1();
    chk_d("watch_60s", show(0, 1));
    chk_b("watch_no_beep", 1'b0);

    // Alarm edit table
    for (int i = 0; i < 18; i++) begin
      mode = vt[i].mode; setValue = vt[i].sv;
      upTime = vt[i].up; nextDigit = vt[i].nd;
      tick1();
      chk_d($sformatf("alarm_row%0d", i), vt[i].exp_digits);
      chk_b($sformatf("alarm_row%0d_beep", i), vt[i].exp_beep);
    end
    upTime = 1'b0; nextDigit = 1'b0;

    // Drive the watch onto the alarm time
    mode = 3'b000; setValue = 1'b1;
    tick1();
    chk_d("watch_edit_entry", show(0, 1));
    press_n(K_UP, 3);
    press(K_ND);
    press_n(K_UP, 2);
    press(K_ND);
    upTime = 1'b1;
    tick1();
    chk_d("watch_set_0124", show(1, 24));
    chk_b("beep_latency", 1'b0);
    upTime = 1'b0;
    tick1();
    chk_b("beep_on", 1'b1);
    tick1();
    chk_b("beep_hold", 1'b1);
    stop = 1'b1;
    tick1();
    chk_b("beep_stop", 1'b0);
    stop = 1'b0;
    repeat (3) tick1();
    chk_b("beep_disarmed", 1'b0);

    // Hour digit limits, cursor at hour ones
    press_n(K_UP, 8);
    chk_d("hr_ones_9", show(9, 24));
    press(K_ND);
    press(K_UP);
    chk_d("hr_tens_1", show(19, 24));
    press(K_UP);
    chk_d("hr_clamp", show(23, 24));
    press_n(K_ND, 3);
    press(K_UP);
    chk_d("hr_ones_wrap", show(20, 24));
    press_n(K_ND, 3);
    press_n(K_UP, 4);
    chk_d("min_tens_wrap", show(20, 4));
    press_n(K_UP, 5);
    press(K_ND);
    press_n(K_UP, 3);
    press_n(K_ND, 2);
    press_n(K_UP, 5);
    chk_d("set_2359", show(23, 59));
    press(K_UP);
    chk_d("min_ones_wrap", show(23, 50));
    press_n(K_UP, 9);

    // Day rollover
    setValue = 1'b0;
    repeat (59) tick1();
    chk_d("pre_midnight", show(23, 59));
    tick1();
    chk_d("midnight", show(0, 0));

    // Stopwatch
    mode = 3'b001;
    start_resume = 1'b1;
    tick1();
    start_resume = 1'b0;
    repeat (125) tick1();
    chk_d("sw_0205", show(2, 5));
    stop = 1'b1;
    tick1();
    stop = 1'b0;
    chk_d("sw_pause", show(2, 5));
    repeat (10) tick1();
    chk_d("sw_frozen", show(2, 5));
    start_resume = 1'b1;
    tick1();
    start_resume = 1'b0;
    repeat (3) tick1();
    chk_d("sw_resume", show(2, 8));
    press(K_ST);
    chk_d("sw_paused2", show(2, 8));
    stop = 1'b1;
    tick1();
    stop = 1'b0;
    chk_d("sw_clear", show(0, 0));

    // Blank modes
    mode = 3'b101; #1 chk_d("blank_101", 28'h0);
    mode = 3'b011; #1 chk_d("blank_011", 28'h0);
    mode = 3'b111; #1 chk_d("blank_111", 28'h0);

    // Mid-run reset
    mode = 3'b001;
    start_resume = 1'b1;
    tick1();
    start_resume = 1'b0;
    repeat (5) tick1();
    chk_d("sw_pre_reset", show(0, 5));
    resetTime = 1'b1;
    tick1();
    chk_d("mid_rst_sw", show(0, 0));
    mode = 3'b000; #1 chk_d("mid_rst_watch", show(0, 0));
    mode = 3'b010; #1 chk_d("mid_rst_alarm", show(0, 0));
    chk_b("mid_rst_beep", 1'b0);
    resetTime = 1'b0;
    mode = 3'b001;
    repeat (5) tick1();
    chk_d("post_rst_sw_stopped", show(0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
